// File: rtl/fetch_stage_pkg.sv
// Core-wide fetch types and constants shared by the fetch stage and its FIFOs.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

   typedef struct packed {
      logic        epoch;
      logic [31:0] pc;
   } pend_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with flush; used for the instruction queue and request tracker.
module fetch_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   input  logic              i_flush,
   output logic [DATA_W-1:0] o_data,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_empty,
   output logic              o_full
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_pop   = i_pop && !o_empty;
   // A full FIFO may still accept a push when the head leaves in the same cycle.
   assign w_push  = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, in-order imem requests with credit flow control, queue and IF/ID register.
// Defining FETCH_PERF_CNT_EN adds stall-cycle and redirect performance counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   input  logic        halt,
   output logic        if_id_valid,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] perf_fetch_stall_cycles,
   output logic [31:0] perf_redirect_count,
`endif
   output logic        fetch_idle
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [31:0]      r_fetch_pc;
   logic             r_epoch;
   logic             r_if_id_valid;
   logic [31:0]      r_if_id_inst;
   logic [31:0]      r_if_id_pc;

   fetch_entry_t     w_q_head;
   fetch_entry_t     w_q_wdata;
   pend_entry_t      w_p_head;
   pend_entry_t      w_p_wdata;
   logic [CNT_W-1:0] w_q_count;
   logic [CNT_W-1:0] w_p_count;
   logic             w_q_empty;
   logic             w_q_full;
   logic             w_p_empty;
   logic             w_p_full;
   logic             w_q_push;
   logic             w_q_pop;
   logic             w_p_pop;
   logic             w_req_fire;
   logic [CNT_W:0]   w_used;
   logic [CNT_W:0]   w_limit;

   // Credit: slots not yet claimed by queued or in-flight instructions, plus the one leaving now.
   assign w_q_pop   = !stall && !w_q_empty;
   assign w_used    = {1'b0, w_q_count} + {1'b0, w_p_count};
   assign w_limit   = (CNT_W + 1)'(DEPTH) + {{CNT_W{1'b0}}, w_q_pop};

   assign imem_req_valid = !reset && !halt && !redirect_valid && !w_p_full && (w_used < w_limit);
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   assign w_p_wdata = '{epoch: r_epoch, pc: r_fetch_pc};
   // Responses with an empty tracker belong to requests issued before a reset.
   assign w_p_pop   = imem_rsp_valid && !w_p_empty;
   assign w_q_push  = w_p_pop && (w_p_head.epoch == r_epoch) && !redirect_valid;
   assign w_q_wdata = '{inst: imem_rsp_data, pc: w_p_head.pc};

   fetch_fifo #(
      .DATA_W ($bits(pend_entry_t)),
      .DEPTH  (DEPTH)
   ) u_pend_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (w_req_fire),
      .i_data  (w_p_wdata),
      .i_pop   (w_p_pop),
      .i_flush (1'b0),
      .o_data  (w_p_head),
      .o_count (w_p_count),
      .o_empty (w_p_empty),
      .o_full  (w_p_full)
   );

   fetch_fifo #(
      .DATA_W ($bits(fetch_entry_t)),
      .DEPTH  (DEPTH)
   ) u_inst_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (w_q_push),
      .i_data  (w_q_wdata),
      .i_pop   (w_q_pop),
      .i_flush (redirect_valid),
      .o_data  (w_q_head),
      .o_count (w_q_count),
      .o_empty (w_q_empty),
      .o_full  (w_q_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_epoch    <= 1'b0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_pc;
         r_epoch    <= ~r_epoch;
      end else if (w_req_fire) begin
         r_fetch_pc <= r_fetch_pc + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || redirect_valid || (!stall && w_q_empty)) begin
         r_if_id_valid <= 1'b0;
         r_if_id_inst  <= NOP_INST;
         r_if_id_pc    <= 32'h0;
      end else if (!stall) begin
         r_if_id_valid <= 1'b1;
         r_if_id_inst  <= w_q_head.inst;
         r_if_id_pc    <= w_q_head.pc;
      end
   end

   assign if_id_valid = r_if_id_valid;
   assign if_id_inst  = r_if_id_inst;
   assign if_id_pc    = r_if_id_pc;
   assign fetch_idle  = w_q_empty && w_p_empty;

   // A response without a reserved queue slot means the credit accounting is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(w_q_push && w_q_full && !w_q_pop));

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_redir;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_stall <= 32'h0;
         r_perf_redir <= 32'h0;
      end else begin
         if (!stall && w_q_empty && !redirect_valid) r_perf_stall <= r_perf_stall + 32'd1;
         if (redirect_valid)                         r_perf_redir <= r_perf_redir + 32'd1;
      end
   end

   assign perf_fetch_stall_cycles = r_perf_stall;
   assign perf_redirect_count     = r_perf_redir;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that drives the IF/ID pipeline register of the 5-stage RISC-V core. It owns the program counter and issues in-order requests to a variable-latency instruction memory over a valid/ready handshake. Returned instructions are buffered in a small queue and presented to decode together with their PC. It honours hazard-unit stalls, EX-stage branch/jump redirects, and the ecall halt.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 2, instruction queue entries; also the maximum number of requests outstanding plus queued (2..8)

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1, core clock, rising edge
- reset, in, 1, synchronous active-high reset
- imem_req_valid, out, 1, fetch request valid
- imem_req_ready, in, 1, memory accepts the request this cycle
- imem_req_addr, out, 32, word-aligned fetch address
- imem_rsp_valid, in, 1, response valid; responses return strictly in request order
- imem_rsp_data, in, 32, instruction word
- redirect_valid, in, 1, taken branch/jump resolved in EX
- redirect_pc, in, 32, redirect target
- stall, in, 1, hazard unit holds IF/ID (same as !IF_ID_write)
- halt, in, 1, ecall seen; stop issuing new requests
- if_id_valid, out, 1, IF/ID holds a real instruction
- if_id_inst, out, 32, IF/ID instruction
- if_id_pc, out, 32, IF/ID instruction address
- fetch_idle, out, 1, no requests outstanding and the queue is empty

## Operation
- fetch_pc register. A request is issued when all of the following hold: !halt, !redirect_valid, and credit > 0.
  - credit = DEPTH − (queue_count + outstanding) + pop_this_cycle.
- Handshake: fetch_pc advances by 4 only when imem_req_valid && imem_req_ready. req_addr stays stable while valid && !ready.
- Outstanding tracker: a DEPTH-entry FIFO of {epoch, pc}.
  - Push on request accept.
  - Pop on imem_rsp_valid.
  - A response whose epoch equals the current epoch is written to the queue with its pc. A mismatching response is dropped.
- Queue:
  - Push occurs on a valid current-epoch response.
  - Pop occurs when !stall and the queue is non-empty.
  - The queue never overflows, by construction of credit. A response arriving with no credit-reserved slot is a design error.
- IF/ID register, updated when !stall:
  - Queue non-empty: load {1, head inst, head pc}.
  - Queue empty: load bubble {0, 32'h0000_0013 (addi x0,x0,0), pc 0}.
  - While stall is high and no redirect occurs, IF/ID holds.
- Redirect has priority over stall, halt and a simultaneous response. In that cycle:
  - fetch_pc ← redirect_pc.
  - epoch toggles.
  - Queue is flushed.
  - IF/ID ← bubble.
  - No request is issued.
  - Outstanding entries keep draining and are discarded by the epoch mismatch.
- Halt: requests stop. In-flight responses still fill the queue, and the queue still drains to IF/ID.

## Timing
- Reset values:
  - fetch_pc = RESET_PC; epoch = 0; queue and tracker empty.
  - imem_req_valid = 0 during the reset cycle.
  - if_id_valid = 0, if_id_inst = 32'h0000_0013, if_id_pc = 0.
  - fetch_idle = 1.
- Reset mid-operation: all state returns to reset values on the next edge. Later responses to earlier requests are ignored, because the tracker is empty.
- Latency: request accepted at cycle t, 1-cycle memory, response at t+1. The instruction is in the queue after edge t+1 and in IF/ID after edge t+2.
- Throughput: with DEPTH ≥ 2, 1-cycle memory and no stalls, one instruction per cycle is sustained.
- First request after reset is issued in the cycle after reset deasserts, with addr = RESET_PC.
- A request issued on the redirect cycle is impossible. The first request to the target is issued the following cycle.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_stall_cycles[31:0] and perf_redirect_count[31:0].
  - perf_fetch_stall_cycles counts cycles with !stall && queue empty && !redirect_valid.
  - perf_redirect_count counts redirect cycles.
  - Both reset to 0 and wrap modulo 2^32.
- FETCH_PERF_CNT_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package (core-wide):
  - NOP_INST = 32'h0000_0013.
  - Typedef fetch_entry_t {inst[31:0], pc[31:0]}.
  - Typedef pend_entry_t {epoch, pc[31:0]}.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO (DATA_W, DEPTH) with push, pop, flush, count, empty and full.
  - Instantiated twice: once for the instruction queue and once for the outstanding tracker.

## Test plan
- Reset, then 1-cycle memory with ready held high → requests to 0x0, 0x4, 0x8, … on consecutive cycles. if_id_pc = 0x0 two edges after the first accept, then +4 every cycle.
- imem_req_ready low for 3 cycles at addr 0x10 → imem_req_addr holds 0x10. No PC skip or duplicate reaches IF/ID.
- stall high for 2 cycles while the queue is full → IF/ID holds; imem_req_valid = 0 (credit exhausted). Sequence resumes without loss.
- Redirect to 0x100 with 2 requests outstanding (3-cycle memory) → both stale responses dropped, IF/ID bubble, next valid if_id_pc = 0x100.
- Redirect and stall in the same cycle → redirect wins: IF/ID becomes a bubble and fetch_pc = target.
- halt asserted with 1 request outstanding → no new requests. The outstanding instruction reaches IF/ID, then fetch_idle = 1 and IF/ID shows bubbles.
